// File: rtl/lock_sequencer.sv
// Pushbutton combination lock sequencer: edge detection, code program/entry,
// compare, open-hold timer and failed-attempt lockout (enabled by LOCK_LOCKOUT_EN).
module lock_sequencer #(
  parameter int unsigned CODE_W        = 6,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned OPEN_TICKS    = 300,
  parameter int unsigned LOCKOUT_TICKS = 500
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic              btn0,
  input  logic              btn1,
  input  logic              btn_set,
  output logic [2:0]        state_code,
  output logic [CODE_W-1:0] password,
  output logic [CODE_W-1:0] entry,
  output logic [3:0]        entry_cnt,
  output logic [1:0]        fail_cnt,
  output logic              open,
  output logic              alarm
);

`ifdef LOCK_LOCKOUT_EN
  localparam bit          LOCKOUT_EN = 1'b1;
  localparam int unsigned TMAX = ((OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS) - 1;
`else
  localparam bit          LOCKOUT_EN = 1'b0;
  localparam int unsigned TMAX = OPEN_TICKS - 1;
`endif
  localparam int unsigned TW = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [2:0] {
    S_EDIT    = 3'd0,
    S_LOCKED  = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CODE_W-1:0] pw_n, en_n;
  logic [3:0]        cnt_n;
  logic [1:0]        fail_n;
  logic [TW-1:0]     tmr, tmr_n;
  logic              b0_q, b1_q, bs_q;
  logic              p0, p1, set_press, bit_press, bit_val;

  // Simultaneous 0/1 presses cancel each other out.
  assign p0        = btn0 & ~b0_q;
  assign p1        = btn1 & ~b1_q;
  assign set_press = btn_set & ~bs_q;
  assign bit_press = p0 ^ p1;
  assign bit_val   = p1;

  assign state_code = state;

  always_comb begin
    state_n = state;
    pw_n    = password;
    en_n    = entry;
    cnt_n   = entry_cnt;
    fail_n  = fail_cnt;
    tmr_n   = tmr;
    case (state)
      S_EDIT: begin
        if (bit_press) pw_n = {password[CODE_W-2:0], bit_val};
        if (set_press) begin
          state_n = S_LOCKED;
          en_n    = '0;
          cnt_n   = '0;
          fail_n  = '0;
        end
      end
      S_LOCKED: begin
        if (bit_press) begin
          en_n  = {entry[CODE_W-2:0], bit_val};
          cnt_n = entry_cnt + 4'd1;
          if (cnt_n == 4'(CODE_W)) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        en_n  = '0;
        cnt_n = '0;
        if (entry == password) begin
          state_n = S_OPEN;
          fail_n  = '0;
          tmr_n   = TW'(OPEN_TICKS - 1);
        end else begin
          fail_n = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
          if (LOCKOUT_EN && (fail_n == 2'(MAX_FAILS))) begin
            state_n = S_LOCKOUT;
            tmr_n   = TW'(LOCKOUT_TICKS - 1);
          end else begin
            state_n = S_LOCKED;
          end
        end
      end
      S_OPEN: begin
        // Re-program request beats timer expiry on the same edge.
        if (set_press)        state_n = S_EDIT;
        else if (tmr == '0)   state_n = S_LOCKED;
        else                  tmr_n   = tmr - TW'(1);
      end
      S_LOCKOUT: begin
        if (tmr == '0) begin
          state_n = S_LOCKED;
          fail_n  = '0;
        end else begin
          tmr_n = tmr - TW'(1);
        end
      end
      default: state_n = S_EDIT;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state     <= S_EDIT;
      password  <= '0;
      entry     <= '0;
      entry_cnt <= '0;
      fail_cnt  <= '0;
      tmr       <= '0;
      open      <= 1'b0;
      b0_q      <= 1'b0;
      b1_q      <= 1'b0;
      bs_q      <= 1'b0;
    end else begin
      state     <= state_n;
      password  <= pw_n;
      entry     <= en_n;
      entry_cnt <= cnt_n;
      fail_cnt  <= fail_n;
      tmr       <= tmr_n;
      open      <= (state_n == S_OPEN);
      b0_q      <= btn0;
      b1_q      <= btn1;
      bs_q      <= btn_set;
    end
  end

`ifdef LOCK_LOCKOUT_EN
  always_ff @(posedge hz100) begin
    if (reset) alarm <= 1'b0;
    else       alarm <= (state_n == S_LOCKOUT);
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: cycle-level behavioural model plus
// directed checks of programming, open timing, lockout, edge detection and reset.
module tb_lock_sequencer;
  localparam int CW = 6;
  localparam int MF = 3;
  localparam int OT = 300;
  localparam int LT = 500;

  logic          hz100 = 1'b0;
  logic          reset = 1'b1;
  logic          btn0 = 1'b0, btn1 = 1'b0, btn_set = 1'b0;
  logic [2:0]    state_code;
  logic [CW-1:0] password, entry;
  logic [3:0]    entry_cnt;
  logic [1:0]    fail_cnt;
  logic          open, alarm;

  lock_sequencer #(
    .CODE_W(CW), .MAX_FAILS(MF), .OPEN_TICKS(OT), .LOCKOUT_TICKS(LT)
  ) dut (
    .hz100(hz100), .reset(reset), .btn0(btn0), .btn1(btn1), .btn_set(btn_set),
    .state_code(state_code), .password(password), .entry(entry),
    .entry_cnt(entry_cnt), .fail_cnt(fail_cnt), .open(open), .alarm(alarm)
  );

  always #5 hz100 = ~hz100;

  int passed = 0;
  int total  = 0;
  bit armed  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: states 0..4, timer counts remaining cycles in the timed state.
  int m_st, m_pw, m_en, m_cnt, m_fail, m_tmr;
  bit h0, h1, hs, q0, q1, qs, valid, bv;

  always @(posedge hz100) begin
    q0 = btn0 && !h0;
    q1 = btn1 && !h1;
    qs = btn_set && !hs;
    h0 = btn0; h1 = btn1; hs = btn_set;
    valid = (q0 != q1);
    bv = q1;
    if (reset) begin
      m_st = 0; m_pw = 0; m_en = 0; m_cnt = 0; m_fail = 0; m_tmr = 0;
      h0 = 0; h1 = 0; hs = 0;
    end else begin
      case (m_st)
        0: begin
          if (valid) m_pw = (m_pw * 2 + int'(bv)) % (1 << CW);
          if (qs) begin m_st = 1; m_en = 0; m_cnt = 0; m_fail = 0; end
        end
        1: if (valid) begin
          m_en = (m_en * 2 + int'(bv)) % (1 << CW);
          m_cnt++;
          if (m_cnt == CW) m_st = 2;
        end
        2: begin
          if (m_en == m_pw) begin
            m_st = 3; m_fail = 0; m_tmr = OT;
          end else begin
            m_fail = (m_fail < 3) ? m_fail + 1 : 3;
`ifdef LOCK_LOCKOUT_EN
            if (m_fail == MF) begin m_st = 4; m_tmr = LT; end
            else m_st = 1;
`else
            m_st = 1;
`endif
          end
          m_en = 0; m_cnt = 0;
        end
        3: begin
          if (qs) m_st = 0;
          else begin
            m_tmr--;
            if (m_tmr == 0) m_st = 1;
          end
        end
        default: begin
          m_tmr--;
          if (m_tmr == 0) begin m_st = 1; m_fail = 0; end
        end
      endcase
    end
  end

  always @(negedge hz100) begin
    if (armed) begin
      chk("state_code", 32'(state_code), m_st);
      chk("password", 32'(password), m_pw);
      chk("entry", 32'(entry), m_en);
      chk("entry_cnt", 32'(entry_cnt), m_cnt);
      chk("fail_cnt", 32'(fail_cnt), m_fail);
      chk("open", 32'(open), 32'(m_st == 3));
      chk("alarm", 32'(alarm), 32'(m_st == 4));
    end
  end

  task automatic tick();
    @(negedge hz100);
  endtask

  task automatic press(input bit b);
    if (b) btn1 = 1'b1; else btn0 = 1'b1;
    tick();
    btn0 = 1'b0; btn1 = 1'b0;
    tick();
  endtask

  task automatic press_set();
    btn_set = 1'b1;
    tick();
    btn_set = 1'b0;
    tick();
  endtask

  // Leaves the final bit held, returning at the negedge just after the CHECK edge.
  task automatic enter_code(input logic [CW-1:0] c);
    for (int i = CW - 1; i >= 1; i--) press(c[i]);
    if (c[0]) btn1 = 1'b1; else btn0 = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n;
  logic [CW-1:0] code;

  initial begin
    @(posedge hz100); #1;
    armed = 1;
    tick();
    chk("rst_state", 32'(state_code), 0);
    chk("rst_password", 32'(password), 0);
    chk("rst_open", 32'(open), 0);
    reset = 1'b0;

    press(1); press(0); press(1); press(0); press(1); press(1);
    press_set();
    chk("prog_password", 32'(password), 32'h2B);
    chk("prog_state", 32'(state_code), 1);
    chk("prog_entry_cnt", 32'(entry_cnt), 0);

    code = 6'b101011;
    enter_code(code);
    chk("check_state", 32'(state_code), 2);
    btn0 = 0; btn1 = 0;
    tick();
    chk("open_state", 32'(state_code), 3);
    n = 0;
    while (open === 1'b1 && n < 1000) begin n++; tick(); end
    chk("open_cycles", n, 300);
    chk("after_open_state", 32'(state_code), 1);
    chk("after_open_fail", 32'(fail_cnt), 0);

    code = '0;
    enter_code(code); btn0 = 0; tick();
    chk("fail1", 32'(fail_cnt), 1);
    chk("fail1_state", 32'(state_code), 1);
    enter_code(code); btn0 = 0; tick();
    chk("fail2", 32'(fail_cnt), 2);
    enter_code(code); btn0 = 0; tick();
`ifdef LOCK_LOCKOUT_EN
    chk("lockout_state", 32'(state_code), 4);
    chk("lockout_alarm", 32'(alarm), 1);
    n = 0;
    while (alarm === 1'b1 && n < 2000) begin
      n++;
      btn1 = (n % 2 == 1);
      btn0 = (n % 3 == 0);
      btn_set = (n % 5 == 0);
      tick();
    end
    btn0 = 0; btn1 = 0; btn_set = 0;
    chk("lockout_cycles", n, 500);
    chk("post_lockout_state", 32'(state_code), 1);
    chk("post_lockout_fail", 32'(fail_cnt), 0);
    tick();
    chk("post_lockout_cnt", 32'(entry_cnt), 0);
`else
    chk("nolockout_state", 32'(state_code), 1);
    chk("nolockout_fail", 32'(fail_cnt), 3);
    chk("nolockout_alarm", 32'(alarm), 0);
`endif

    btn1 = 1'b1;
    repeat (50) tick();
    chk("hold_cnt", 32'(entry_cnt), 1);
    btn1 = 1'b0;
    tick();
    btn0 = 1'b1; btn1 = 1'b1;
    tick();
    chk("simul_cnt", 32'(entry_cnt), 1);
    chk("simul_entry", 32'(entry), 1);
    btn0 = 1'b0; btn1 = 1'b0;
    tick();
    press(1); press(0); press(1);
    chk("four_bits_cnt", 32'(entry_cnt), 4);
    chk("four_bits_entry", 32'(entry), 13);

    reset = 1'b1;
    tick();
    chk("midrst_state", 32'(state_code), 0);
    chk("midrst_password", 32'(password), 0);
    chk("midrst_entry", 32'(entry), 0);
    chk("midrst_cnt", 32'(entry_cnt), 0);
    chk("midrst_fail", 32'(fail_cnt), 0);
    reset = 1'b0;
    tick();

    press(1); press(0); press(1); press(0); press(1); press(1);
    press_set();
    code = 6'b101011;
    enter_code(code);
    btn0 = 0; btn1 = 0;
    tick();
    repeat (299) tick();
    chk("pre_expiry_open", 32'(open), 1);
    btn_set = 1'b1;
    tick();
    chk("set_at_expiry_state", 32'(state_code), 0);
    chk("set_at_expiry_open", 32'(open), 0);
    btn_set = 1'b0;
    tick();

    armed = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
